dual_issue_scoreboard: RTL and testbench

- Issue-side hazard scoreboard for the dual-issue pipeline.
- Tracks every producer that leaves Decode whose result cannot yet be forwarded: loads, and multi-cycle multiply/divide (MDU) ops.
- From that state it decides whether both Decode slots, slot 1 only, or neither may issue this cycle.
- It is the producer-side counterpart of the Execute-stage forwarding unit: anything the scoreboard lets issue is guaranteed to have its operands available from the forwarding paths or the register file.

---
 rtl/dual_issue_scoreboard_pkg.sv | 21 ++
 rtl/dual_issue_scoreboard_if.sv | 30 +++
 rtl/dual_issue_scoreboard_pend_counter.sv | 42 ++++
 rtl/dual_issue_scoreboard.sv | 77 +++++++
 tb/tb_dual_issue_scoreboard.sv | 128 ++++++++++++
 5 files changed

// File: rtl/dual_issue_scoreboard_pkg.sv
// Shared pipeline constants for the issue-side scoreboard and the Execute
// forwarding unit: register file geometry, producer latencies and the
// forwarding-select encoding both units agree on.
package dual_issue_scoreboard_pkg;

  localparam int unsigned NREG     = 32;
  localparam int unsigned REG_W    = $clog2(NREG);
  localparam int unsigned LOAD_LAT = 1;
  localparam int unsigned MDU_LAT  = 4;
  localparam int unsigned CNT_W    = 3;

  typedef logic [REG_W-1:0] reg_idx_t;

  // Operand source selected by the Execute-stage forwarding unit.
  typedef enum logic [1:0] {
    FwdRf  = 2'b00,
    FwdWb  = 2'b01,
    FwdMem = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/dual_issue_scoreboard_if.sv
// Decode-slot bundle between the D stage and the scoreboard.
//   master: drives the two slot descriptors and flush_e, reads the decision.
//   slave : the scoreboard; reads the slots, drives stall_d/issue2_d/mdu_busy.
interface dual_issue_scoreboard_if;
  import dual_issue_scoreboard_pkg::*;

  logic     valid_d1, valid_d2;
  reg_idx_t rs_d1, rt_d1, rs_d2, rt_d2;
  reg_idx_t write_reg_d1, write_reg_d2;
  logic     reg_write_d1, reg_write_d2;
  logic     mem_read_d1, mem_read_d2;
  logic     mdu_d1, mdu_d2;
  logic     flush_e;
  logic     stall_d;
  logic     issue2_d;
  logic     mdu_busy;

  modport master (
    output valid_d1, valid_d2, rs_d1, rt_d1, rs_d2, rt_d2, write_reg_d1, write_reg_d2,
           reg_write_d1, reg_write_d2, mem_read_d1, mem_read_d2, mdu_d1, mdu_d2, flush_e,
    input  stall_d, issue2_d, mdu_busy
  );

  modport slave (
    input  valid_d1, valid_d2, rs_d1, rt_d1, rs_d2, rt_d2, write_reg_d1, write_reg_d2,
           reg_write_d1, reg_write_d2, mem_read_d1, mem_read_d2, mdu_d1, mdu_d2, flush_e,
    output stall_d, issue2_d, mdu_busy
  );

endinterface

// File: rtl/dual_issue_scoreboard_pend_counter.sv
// Loadable down-counter with a "young" tag, one per tracked register (and
// one for MDU occupancy).
//   clk_i, rst_ni : clock, async active-low reset
//   flush_i       : squash the entry if it was loaded last cycle
//   set_i         : load set_val_i this cycle (beats flush and decrement)
//   cnt_o         : flush-adjusted count, i.e. the value the D stage sees now
module dual_issue_scoreboard_pend_counter #(
  parameter int unsigned CntW = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            set_i,
  input  logic [CntW-1:0] set_val_i,
  output logic [CntW-1:0] cnt_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            young_q, young_d;

  always_comb begin
    // A flush removes last cycle's producer before anyone looks at it.
    cnt_o   = (flush_i && young_q) ? '0 : cnt_q;
    cnt_d   = (cnt_o != '0) ? cnt_o - CntW'(1) : '0;
    young_d = 1'b0;
    if (set_i) begin
      cnt_d   = set_val_i;
      young_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      young_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      young_q <= young_d;
    end
  end

endmodule

// File: rtl/dual_issue_scoreboard.sv
// Issue-side hazard scoreboard for the dual-issue pipeline. Tracks loads and
// MDU results that cannot be forwarded yet and decides whether both Decode
// slots, slot 1 only, or neither issue this cycle.
//   clk_i, rst_ni : clock, async active-low reset
//   bus (slave)   : Decode slot descriptors, flush_e; stall_d, issue2_d, mdu_busy
module dual_issue_scoreboard
  import dual_issue_scoreboard_pkg::*;
#(
  parameter int unsigned Nreg    = NREG,
  parameter int unsigned LoadLat = LOAD_LAT,
  parameter int unsigned MduLat  = MDU_LAT,
  parameter int unsigned CntW    = CNT_W
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  dual_issue_scoreboard_if.slave   bus
);

  logic [CntW-1:0] pend [Nreg];
  logic [CntW-1:0] mdu_cnt;
  logic [CntW-1:0] val1, val2;
  logic            haz1, haz2, raw12, issue1, issue2, mdu_issue;

  // r0 is hard-wired, so reads of it never stall.
  assign pend[0] = '0;

  always_comb begin
    haz1 = bus.valid_d1 & ((pend[bus.rs_d1] != '0) | (pend[bus.rt_d1] != '0) |
                           (bus.mdu_d1 & (mdu_cnt != '0)));
    raw12 = bus.reg_write_d1 & (bus.write_reg_d1 != '0) &
            ((bus.rs_d2 == bus.write_reg_d1) | (bus.rt_d2 == bus.write_reg_d1));
    haz2 = bus.valid_d2 & ((pend[bus.rs_d2] != '0) | (pend[bus.rt_d2] != '0) |
                           (bus.mdu_d2 & (mdu_cnt != '0)) | raw12 |
                           (bus.mdu_d1 & bus.mdu_d2));
    issue1    = bus.valid_d1 & ~haz1;
    issue2    = ~haz1 & bus.valid_d2 & ~haz2;
    mdu_issue = (issue1 & bus.mdu_d1) | (issue2 & bus.mdu_d2);
    // ALU writers load 0, cancelling any older pending entry.
    val1 = bus.mem_read_d1 ? CntW'(LoadLat) : bus.mdu_d1 ? CntW'(MduLat) : '0;
    val2 = bus.mem_read_d2 ? CntW'(LoadLat) : bus.mdu_d2 ? CntW'(MduLat) : '0;
  end

  assign bus.stall_d  = haz1;
  assign bus.issue2_d = issue2;
  assign bus.mdu_busy = (mdu_cnt != '0);

  for (genvar r = 1; r < Nreg; r++) begin : g_reg
    logic set1, set2;
    assign set1 = issue1 & bus.reg_write_d1 & (bus.write_reg_d1 == REG_W'(r));
    assign set2 = issue2 & bus.reg_write_d2 & (bus.write_reg_d2 == REG_W'(r));

    // Slot 2 is younger, so its value wins on a shared destination.
    dual_issue_scoreboard_pend_counter #(
      .CntW (CntW)
    ) u_pend (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .flush_i   (bus.flush_e),
      .set_i     (set1 | set2),
      .set_val_i (set2 ? val2 : val1),
      .cnt_o     (pend[r])
    );
  end

  // MDU occupancy follows exactly the same set/flush/decrement rules.
  dual_issue_scoreboard_pend_counter #(
    .CntW (CntW)
  ) u_mdu_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush_i   (bus.flush_e),
    .set_i     (mdu_issue),
    .set_val_i (CntW'(MduLat)),
    .cnt_o     (mdu_cnt)
  );

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
module tb_dual_issue_scoreboard;
  import dual_issue_scoreboard_pkg::*;

  typedef struct packed {
    logic     v;
    reg_idx_t rs, rt, wr;
    logic     rw, mem, mdu;
  } slot_t;

  typedef struct {
    string tag;
    logic  stall, iss2, busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_fail = 0;
  exp_t q[$];

  dual_issue_scoreboard_if bus ();

  dual_issue_scoreboard dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic slot_t nop_op();
    return '0;
  endfunction

  function automatic slot_t alu_op(int wr, int rs, int rt);
    slot_t s = '0;
    s.v = 1'b1; s.rw = 1'b1;
    s.wr = reg_idx_t'(wr); s.rs = reg_idx_t'(rs); s.rt = reg_idx_t'(rt);
    return s;
  endfunction

  function automatic slot_t ld_op(int wr, int rs);
    slot_t s = alu_op(wr, rs, 0);
    s.mem = 1'b1;
    return s;
  endfunction

  function automatic slot_t mdu_op(int wr, int rs, int rt);
    slot_t s = alu_op(wr, rs, rt);
    s.mdu = 1'b1;
    return s;
  endfunction

  // One D-stage cycle: drive at negedge, queue the expectation, check before
  // the next rising edge commits state.
  task automatic cyc(input string tag, input logic rst_v, input slot_t s1, input slot_t s2,
                     input logic flush, input logic e_stall, input logic e_iss2,
                     input logic e_busy);
    exp_t e;
    @(negedge clk);
    rst_n            = rst_v;
    bus.valid_d1     = s1.v;   bus.valid_d2     = s2.v;
    bus.rs_d1        = s1.rs;  bus.rs_d2        = s2.rs;
    bus.rt_d1        = s1.rt;  bus.rt_d2        = s2.rt;
    bus.write_reg_d1 = s1.wr;  bus.write_reg_d2 = s2.wr;
    bus.reg_write_d1 = s1.rw;  bus.reg_write_d2 = s2.rw;
    bus.mem_read_d1  = s1.mem; bus.mem_read_d2  = s2.mem;
    bus.mdu_d1       = s1.mdu; bus.mdu_d2       = s2.mdu;
    bus.flush_e      = flush;
    q.push_back('{tag: tag, stall: e_stall, iss2: e_iss2, busy: e_busy});
    #2;
    e = q.pop_front();
    n_vec++;
    assert (bus.stall_d === e.stall) else begin
      n_fail++;
      $error("FAIL %s stall_d observed=%b expected=%b", e.tag, bus.stall_d, e.stall);
    end
    n_vec++;
    assert (bus.issue2_d === e.iss2) else begin
      n_fail++;
      $error("FAIL %s issue2_d observed=%b expected=%b", e.tag, bus.issue2_d, e.iss2);
    end
    n_vec++;
    assert (bus.mdu_busy === e.busy) else begin
      n_fail++;
      $error("FAIL %s mdu_busy observed=%b expected=%b", e.tag, bus.mdu_busy, e.busy);
    end
  endtask

  initial begin
    bus.valid_d1 = 0; bus.valid_d2 = 0; bus.rs_d1 = 0; bus.rt_d1 = 0; bus.rs_d2 = 0;
    bus.rt_d2 = 0; bus.write_reg_d1 = 0; bus.write_reg_d2 = 0; bus.reg_write_d1 = 0;
    bus.reg_write_d2 = 0; bus.mem_read_d1 = 0; bus.mem_read_d2 = 0; bus.mdu_d1 = 0;
    bus.mdu_d2 = 0; bus.flush_e = 0;

    // tag          rst  slot1               slot2              flush stall iss2 busy
    cyc("rst_raw",    0, alu_op(1, 2, 3),    alu_op(4, 1, 6),    0,    0,    0,   0);
    cyc("indep",      1, alu_op(1, 2, 3),    alu_op(4, 5, 6),    0,    0,    1,   0);
    cyc("ld_r5",      1, ld_op(5, 2),        nop_op(),           0,    0,    0,   0);
    cyc("ld_use",     1, alu_op(6, 5, 0),    nop_op(),           0,    1,    0,   0);
    cyc("ld_go",      1, alu_op(6, 5, 0),    nop_op(),           0,    0,    0,   0);
    cyc("pair_raw",   1, alu_op(3, 1, 2),    alu_op(7, 1, 3),    0,    0,    0,   0);
    cyc("held_go",    1, alu_op(7, 1, 3),    nop_op(),           0,    0,    0,   0);
    cyc("mdu_r8",     1, mdu_op(8, 1, 2),    nop_op(),           0,    0,    0,   0);
    cyc("mdu_use1",   1, alu_op(9, 8, 0),    nop_op(),           0,    1,    0,   1);
    cyc("mdu_use2",   1, alu_op(9, 8, 0),    nop_op(),           0,    1,    0,   1);
    cyc("mdu_mdu3",   1, mdu_op(10, 1, 2),   nop_op(),           0,    1,    0,   1);
    cyc("mdu_mdu4",   1, mdu_op(10, 1, 2),   nop_op(),           0,    1,    0,   1);
    cyc("mdu_done",   1, mdu_op(10, 1, 2),   alu_op(11, 8, 1),   0,    0,    1,   0);
    cyc("mdu_flush",  1, mdu_op(12, 1, 2),   alu_op(13, 10, 0),  1,    0,    1,   0);
    cyc("refill",     1, alu_op(14, 12, 0),  nop_op(),           0,    1,    0,   1);
    cyc("rst_mid",    0, alu_op(14, 12, 0),  nop_op(),           0,    0,    0,   0);
    cyc("rst_rel",    1, alu_op(14, 12, 0),  nop_op(),           0,    0,    0,   0);
    cyc("ld_r9",      1, ld_op(9, 1),        nop_op(),           0,    0,    0,   0);
    cyc("ld_flush",   1, alu_op(15, 9, 0),   nop_op(),           1,    0,    0,   0);
    cyc("same_wr",    1, mdu_op(7, 1, 2),    ld_op(7, 3),        0,    0,    1,   0);
    cyc("s2_wins1",   1, alu_op(16, 7, 0),   nop_op(),           0,    1,    0,   1);
    cyc("s2_wins2",   1, alu_op(16, 7, 0),   nop_op(),           0,    0,    0,   1);
    cyc("ld_r0",      1, ld_op(0, 1),        alu_op(17, 0, 0),   0,    0,    1,   1);
    cyc("rd_r0",      1, alu_op(18, 0, 0),   alu_op(19, 0, 0),   0,    0,    1,   1);
    cyc("mdu_pair",   1, mdu_op(20, 1, 2),   mdu_op(21, 3, 4),   0,    0,    0,   0);
    cyc("s2_pend",    1, alu_op(22, 1, 2),   alu_op(23, 20, 0),  0,    0,    0,   1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
